int_sched: RTL
==============

# int_sched

Interrupt scheduler for the 8051 core: sits between `IntControl`, which produces the enabled, pending interrupt flags, and the CPU sequencer.

- Samples the five request lines.
- Resolves the two-level priority (IP) and the fixed polling order.
- Enforces nesting rules with an in-service register per level.
- Presents a vector plus request to the CPU, handshaking on LCALL injection and RETI.
- On acknowledge, pulses hardware-clear strobes back to the TCON flags.

## Interface
- `NSRC`, 5, number of interrupt sources; fixed order is IE0, TF0, IE1, TF1, SER.
- `VEC_BASE`, 16'h0003, vector of source 0.
- `VEC_STRIDE`, 8, vector spacing in bytes.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NSRC  pending, enable-gated flags from `IntControl.interupt`; bit i = source i.
- `ea`  in  1  IE[7] global enable.
- `ip`  in  NSRC  IP[4:0]; 1 = high priority.
- `boundary`  in  1  CPU is at an instruction boundary this cycle.
- `hold`  in  1  current instruction is RETI or writes IE/IP; blocks vectoring for this boundary.
- `int_ack`  in  1  CPU has injected the LCALL for the presented vector.
- `reti`  in  1  one-cycle pulse when RETI executes.
- `int_req`  out  1  vector pending to CPU.
- `int_vec`  out  16  LCALL target.
- `int_src`  out  3  index of the presented source.
- `clr_flag`  out  4  one-cycle hardware clear for IE0, TF0, IE1, TF1; SER is never cleared by hardware.
- `in_svc`  out  2  in-service bits: [1] = high, [0] = low.

## Operation
- Sample register: `req_q <= req & {NSRC{ea}}` every cycle while `state == IDLE`. It holds its value in PEND.
- Eligibility:
  - If `in_svc[1]`: no source is eligible.
  - Else if `in_svc[0]`: only sources with `ip=1` are eligible.
  - Else: all sources are eligible.
- Selection:
  - Among eligible sources, the high-level set wins if it is non-empty.
  - Within a level, the lowest index wins.
- States:
  - IDLE -> PEND when `boundary & ~hold` and an eligible source exists. On that edge, latch `int_src` and `int_vec = VEC_BASE + VEC_STRIDE*int_src`, and set `int_req=1`.
  - PEND -> IDLE on `int_ack`. On that edge:
    - `int_req <= 0`.
    - `clr_flag[int_src] <= 1` for one cycle, only if `int_src < 4`.
    - Set `in_svc[ip_lat]`, where `ip_lat` is the `ip` bit captured together with `int_src`.
- PEND is committed:
  - Deassertion of `req`, `ea` or `ip` does not cancel it.
  - `int_vec` and `int_src` stay stable until ack.
- RETI: clears `in_svc[1]` if it is set, else `in_svc[0]`. With neither set, RETI is ignored.
- `reti` and `int_ack` in the same cycle: apply the RETI clear first, then set the acked level.
- `boundary` in PEND is ignored.
- `int_vec` is computed in 16-bit arithmetic. The maximum value 16'h0023 cannot overflow.

## Timing
- Reset values: `int_req=0`, `int_vec=16'h0000`, `int_src=0`, `clr_flag=0`, `in_svc=2'b00`, `req_q=0`, state IDLE.
- Reset mid-PEND aborts the request: no `clr_flag` pulse, `in_svc` cleared.
- Latency:
  - `req` high in cycle N, with `boundary` high in cycle N+1 -> `int_req` high in cycle N+2.
  - If `boundary` is low, wait for the next boundary. `req_q` keeps refreshing meanwhile.
- `int_ack` sampled in cycle M -> `int_req` low and `clr_flag` high in cycle M+1. `clr_flag` is low again in M+2.
- A new PEND cannot start before cycle M+2, because `req_q` refreshes in cycle M+1. This prevents double-vectoring on the just-cleared flag.
- `int_ack` while IDLE is ignored.
- `in_svc` updates become visible the cycle after the `reti` or `int_ack` edge. Eligibility uses the registered `in_svc`.

## Structure
- Shared package `int_pkg`:
  - Source index constants: `SRC_IE0`=0 … `SRC_SER`=4.
  - `VEC_BASE`, `VEC_STRIDE`.
  - State enum {IDLE, PEND}.
- Sub-module `int_prio_enc`: combinational NSRC-to-index priority encoder with a valid output, instantiated twice (high level and low level).
- Top level holds `req_q`, the FSM, the `in_svc` register and the vector latch.

## Test plan
- Reset behaviour: `rst` held for 3 cycles with `req`=5'b11111 -> all outputs at reset values. After release, with `boundary`=1, `int_req` rises 2 cycles later with `int_vec`=16'h0003.
- Fixed polling order: `req`=5'b01010, `ip`=0, `ea`=1, `boundary`=1 -> `int_src`=1, `int_vec`=16'h000B. Ack -> `clr_flag`=4'b0010 for exactly one cycle, `in_svc`=2'b01.
- Preemption: with `in_svc`=01 (TF0 in service), assert `req`[4] with `ip`[4]=1 -> `int_vec`=16'h0023. Ack -> `clr_flag`=0, `in_svc`=11. Two `reti` pulses -> 01, then 00.
- Blocking:
  - `in_svc`=10 with any `req` -> `int_req` stays 0 until `reti`.
  - `hold`=1 on a boundary -> no request at that boundary; the request is issued at the next boundary with `hold`=0.
- Committed request: in PEND, drop `req` and `ea` -> `int_vec` stays stable and the ack is still honoured. Also check `reti` and `int_ack` in the same cycle with `in_svc`=01 and a high-level ack -> `in_svc`=10.
- Reset mid-PEND: `rst` asserted while `int_req`=1 -> next cycle `int_req`=0, `in_svc`=00, no `clr_flag` pulse.

Source files
------------

// File: rtl/int_pkg.sv
// Shared definitions for the 8051 interrupt scheduler: source indices,
// vector layout, FSM state encoding and the vector-address helper.
package int_pkg;

    localparam int NSRC = 5;

    localparam logic [2:0] SRC_IE0 = 3'd0;
    localparam logic [2:0] SRC_TF0 = 3'd1;
    localparam logic [2:0] SRC_IE1 = 3'd2;
    localparam logic [2:0] SRC_TF1 = 3'd3;
    localparam logic [2:0] SRC_SER = 3'd4;

    localparam logic [15:0] VEC_BASE   = 16'h0003;
    localparam logic [15:0] VEC_STRIDE = 16'd8;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // LCALL target for a source index; the largest index yields 16'h0023,
    // so 16-bit arithmetic never wraps.
    function automatic logic [15:0] vec_of(input logic [2:0] src);
        return VEC_BASE + VEC_STRIDE * {13'b0, src};
    endfunction

endpackage

// File: rtl/int_sched_if.sv
// Bundle of request, priority, CPU handshake and status signals between
// IntControl / the CPU sequencer (master) and the scheduler (slave).
interface int_sched_if;
    import int_pkg::*;

    logic [NSRC-1:0] req;
    logic            ea;
    logic [NSRC-1:0] ip;
    logic            boundary;
    logic            hold;
    logic            int_ack;
    logic            reti;
    logic            int_req;
    logic [15:0]     int_vec;
    logic [2:0]      int_src;
    logic [3:0]      clr_flag;
    logic [1:0]      in_svc;

    modport master (
        output req, ea, ip, boundary, hold, int_ack, reti,
        input  int_req, int_vec, int_src, clr_flag, in_svc
    );

    modport slave (
        input  req, ea, ip, boundary, hold, int_ack, reti,
        output int_req, int_vec, int_src, clr_flag, in_svc
    );

endinterface

// File: rtl/int_prio_enc.sv
// Combinational priority encoder: reports the lowest set bit index of an
// N-bit request set, plus whether any bit is set.
module int_prio_enc #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  set,
    output logic [IW-1:0] idx,
    output logic          vld
);

    // Scan from the top down so the lowest set index is the last to write idx.
    always_comb begin
        idx = '0;
        vld = |set;
        for (int i = N - 1; i >= 0; i--) begin
            if (set[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_sched.sv
// 8051 interrupt scheduler: samples enable-gated requests, resolves the
// two-level priority with fixed polling order, tracks in-service levels for
// nesting, and hands a vector to the CPU with an LCALL/RETI handshake.
module int_sched
    import int_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    int_sched_if.slave bus
);

    state_t          state, state_nxt;
    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] hi_set, lo_set;
    logic [2:0]      hi_idx, lo_idx, sel_idx;
    logic            hi_vld, lo_vld;
    logic            launch, ack_fire;
    logic            ip_lat;
    logic [1:0]      svc_q, svc_nxt;
    logic            int_req_q;
    logic [15:0]     vec_q;
    logic [2:0]      src_q;
    logic [3:0]      clr_q;

    // Sample the gated request lines only while idle; a pending vector freezes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (state == IDLE) begin
            req_q <= bus.req & {NSRC{bus.ea}};
        end
    end

    // Eligibility from the registered in-service bits: high level blocks all,
    // low level admits only high-priority sources.
    always_comb begin
        hi_set = svc_q[1] ? '0 : (req_q & bus.ip);
        lo_set = (|svc_q) ? '0 : (req_q & ~bus.ip);
    end

    int_prio_enc #(.N(NSRC), .IW(3)) u_enc_hi (
        .set (hi_set),
        .idx (hi_idx),
        .vld (hi_vld)
    );

    int_prio_enc #(.N(NSRC), .IW(3)) u_enc_lo (
        .set (lo_set),
        .idx (lo_idx),
        .vld (lo_vld)
    );

    assign sel_idx = hi_vld ? hi_idx : lo_idx;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: vector at an unheld boundary, return to idle on LCALL ack.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ack_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.boundary && !bus.hold && (hi_vld || lo_vld)) begin
                    launch    = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (bus.int_ack) begin
                    ack_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In-service update: RETI retires the highest active level first, then
    // an acknowledge marks the level of the vector just taken.
    always_comb begin
        svc_nxt = svc_q;
        if (bus.reti) begin
            if (svc_nxt[1]) begin
                svc_nxt[1] = 1'b0;
            end else begin
                svc_nxt[0] = 1'b0;
            end
        end
        if (ack_fire) begin
            svc_nxt[ip_lat] = 1'b1;
        end
    end

    // In-service register.
    always_ff @(posedge clk) begin
        if (rst) begin
            svc_q <= 2'b00;
        end else begin
            svc_q <= svc_nxt;
        end
    end

    // Vector latch, request flag and one-cycle hardware-clear strobes; the
    // serial source has no hardware-cleared flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_req_q <= 1'b0;
            vec_q     <= 16'h0000;
            src_q     <= 3'd0;
            ip_lat    <= 1'b0;
            clr_q     <= 4'b0000;
        end else begin
            clr_q <= (ack_fire && (src_q < SRC_SER)) ? (4'b0001 << src_q[1:0]) : 4'b0000;
            if (launch) begin
                int_req_q <= 1'b1;
                src_q     <= sel_idx;
                vec_q     <= vec_of(sel_idx);
                ip_lat    <= hi_vld;
            end else if (ack_fire) begin
                int_req_q <= 1'b0;
            end
        end
    end

    assign bus.int_req  = int_req_q;
    assign bus.int_vec  = vec_q;
    assign bus.int_src  = src_q;
    assign bus.clr_flag = clr_q;
    assign bus.in_svc   = svc_q;

endmodule
